// File: rtl/csr_fifo_writer_if.sv
// ---------------------------------------------------------------------------
// csr_fifo_writer_if
// Bundles the signals between the CSR FIFO write end and its neighbours:
// the decode-side drive/free handshake, the Gray pointer exchange with the
// CSR issue reader, the reader's combinational storage read port, and the
// write-side status flags.
//
// Signals (named from the FIFO writer's point of view):
//   i_DriveFromDecode_1          instruction valid from decode
//   o_FreeToDecode_1             FIFO can accept (not full)
//   i_InstructionFromDecode_113  instruction to enqueue
//   o_CSRCount_5                 registered Gray write pointer to the reader
//   i_CsrReadPtr_5               reader Gray read pointer (reader clock domain)
//   i_CsrReadAddr_4              reader storage index
//   o_CsrReadData_113            storage[i_CsrReadAddr_4], combinational
//   o_Full_1                     registered full flag
//   o_IsFirst_1                  high until the first accepted write
//   o_Level_5                    write-side occupancy estimate
//
// Modports:
//   slave  - the FIFO writer itself
//   master - the surrounding decode/reader logic (or a testbench)
// ---------------------------------------------------------------------------
interface csr_fifo_writer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 113
);
    logic              i_DriveFromDecode_1;
    logic              o_FreeToDecode_1;
    logic [DATA_W-1:0] i_InstructionFromDecode_113;
    logic [ADDR_W:0]   o_CSRCount_5;
    logic [ADDR_W:0]   i_CsrReadPtr_5;
    logic [ADDR_W-1:0] i_CsrReadAddr_4;
    logic [DATA_W-1:0] o_CsrReadData_113;
    logic              o_Full_1;
    logic              o_IsFirst_1;
    logic [ADDR_W:0]   o_Level_5;

    modport slave (
        input  i_DriveFromDecode_1,
        output o_FreeToDecode_1,
        input  i_InstructionFromDecode_113,
        output o_CSRCount_5,
        input  i_CsrReadPtr_5,
        input  i_CsrReadAddr_4,
        output o_CsrReadData_113,
        output o_Full_1,
        output o_IsFirst_1,
        output o_Level_5
    );

    modport master (
        output i_DriveFromDecode_1,
        input  o_FreeToDecode_1,
        output i_InstructionFromDecode_113,
        input  o_CSRCount_5,
        output i_CsrReadPtr_5,
        output i_CsrReadAddr_4,
        input  o_CsrReadData_113,
        input  o_Full_1,
        input  o_IsFirst_1,
        input  o_Level_5
    );
endinterface

// File: rtl/csr_fifo_writer.sv
// ---------------------------------------------------------------------------
// csr_fifo_writer
// Write end of the CSR instruction FIFO feeding the CSR issue stage.
// Decoded instructions are accepted over a drive/free handshake into a
// 2**ADDR_W entry buffer. The write pointer is published in Gray code for the
// reader's empty detection; the reader's Gray pointer comes back through a
// SYNC_STAGES flop synchronizer and drives the full flag and level estimate.
//
// Ports:
//   clk   write-side clock
//   rstn  asynchronous active-low reset (shared with the reader)
//   bus   csr_fifo_writer_if.slave, see the interface file for signal list
// ---------------------------------------------------------------------------
module csr_fifo_writer #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 113,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    csr_fifo_writer_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W:0]   r_wbin;
    logic [ADDR_W:0]   r_gray;
    logic [ADDR_W:0]   r_sync [SYNC_STAGES];
    logic              r_full;
    logic              r_isFirst;
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic [ADDR_W:0]   w_wbinNext;
    logic [ADDR_W:0]   w_grayNext;
    logic [ADDR_W:0]   w_rq;
    logic [ADDR_W:0]   w_rqBin;
    logic [ADDR_W:0]   w_fullMatch;

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_accept   = bus.i_DriveFromDecode_1 & ~r_full;
    assign w_wbinNext = r_wbin + (ADDR_W+1)'(w_accept);
    assign w_grayNext = (w_wbinNext >> 1) ^ w_wbinNext;
    assign w_rq       = r_sync[SYNC_STAGES-1];
    assign w_rqBin    = gray2bin(w_rq);

    // Full when the writer is exactly one lap ahead of the reader: in Gray
    // code that is the reader pointer with its two top bits inverted.
    assign w_fullMatch = {~w_rq[ADDR_W:ADDR_W-1], w_rq[ADDR_W-2:0]};

    // Pointers, flags and the level estimate. Full and level look at the
    // synchronized (stale) reader pointer, so both err on the safe side.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wbin    <= '0;
            r_gray    <= '0;
            r_full    <= 1'b0;
            r_isFirst <= 1'b1;
            r_level   <= '0;
        end else begin
            r_wbin  <= w_wbinNext;
            r_gray  <= w_grayNext;
            r_full  <= (w_grayNext == w_fullMatch);
            r_level <= w_wbinNext - w_rqBin;
            if (w_accept) begin
                r_isFirst <= 1'b0;
            end
        end
    end

    // Only the Gray-coded reader pointer crosses into this clock domain,
    // so a sampling error can shift it by at most one position.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.i_CsrReadPtr_5;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Storage. Writes are gated by accept, which already excludes full,
    // so an unread entry can never be overwritten.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_wbin[ADDR_W-1:0]] <= bus.i_InstructionFromDecode_113;
        end
    end

    assign bus.o_FreeToDecode_1  = ~r_full;
    assign bus.o_Full_1          = r_full;
    assign bus.o_CSRCount_5      = r_gray;
    assign bus.o_IsFirst_1       = r_isFirst;
    assign bus.o_Level_5         = r_level;
    assign bus.o_CsrReadData_113 = r_mem[bus.i_CsrReadAddr_4];

endmodule
